aes_sbox_lane_arbiter: RTL and testbench

//  Sequences a 128-bit AES SubBytes step through one shared 32-bit S-box lane
//  (four byte S-boxes, combinational, outside this block), one word per cycle.

---
 rtl/aes_sbox_lane_arbiter.sv | 113 +++++++++++
 tb/tb_aes_sbox_lane_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_lane_arbiter.sv
// Serialises AES SubBytes over one shared 32-bit S-box lane, one word per cycle,
// and arbitrates that lane with the key-schedule SubWord requester.
module aes_sbox_lane_arbiter #(
  parameter bit KEY_PRIO = 1'b1,
  parameter int NWORDS   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_in,
  output logic         st_out_valid,
  input  logic         st_out_ready,
  output logic [127:0] st_out,
  input  logic         key_req,
  input  logic [31:0]  key_word,
  output logic         key_done,
  output logic [31:0]  key_sub,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out
);

  localparam logic [1:0] LAST = 2'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   idx;
  logic [127:0] blk;
  logic [31:0]  cur_word;
  logic         key_grant;
  logic         key_win;
  logic         st_grant;
  logic         accept;

  always_comb begin
    cur_word = blk[127:96];
    case (idx)
      2'd0: cur_word = blk[127:96];
      2'd1: cur_word = blk[95:64];
      2'd2: cur_word = blk[63:32];
      2'd3: cur_word = blk[31:0];
      default: cur_word = blk[127:96];
    endcase
  end

  // key_done doubles as the requester's recovery cycle: no regrant while it is high
  assign key_grant = key_req & ~key_done;
  assign key_win   = key_grant & ((state != RUN) | KEY_PRIO);
  assign st_grant  = (state == RUN) & ~key_win;
  assign st_ready  = (state == IDLE) | ((state == DONE) & st_out_ready);
  assign accept    = st_valid & st_ready;
  assign sbox_in   = key_win ? key_word : cur_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 2'd0;
      blk          <= '0;
      st_out       <= '0;
      st_out_valid <= 1'b0;
      key_done     <= 1'b0;
      key_sub      <= '0;
    end else begin
      key_done <= key_win;
      if (key_win) key_sub <= sbox_out;

      case (state)
        IDLE: begin
          if (accept) begin
            blk   <= st_in;
            idx   <= 2'd0;
            state <= RUN;
          end
        end
        RUN: begin
          if (st_grant) begin
            case (idx)
              2'd0: st_out[127:96] <= sbox_out;
              2'd1: st_out[95:64]  <= sbox_out;
              2'd2: st_out[63:32]  <= sbox_out;
              2'd3: st_out[31:0]   <= sbox_out;
              default: st_out[127:96] <= sbox_out;
            endcase
            idx <= idx + 2'd1;
            if (idx == LAST) begin
              state        <= DONE;
              st_out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (st_out_ready) begin
            st_out_valid <= 1'b0;
            if (st_valid) begin
              blk   <= st_in;
              idx   <= 2'd0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sbox_lane_arbiter.sv
// Scoreboard bench: the lane S-box and expected results come from a GF(2^8)
// inverse + affine model; a monitor pops expectations when the DUT presents data.
module tb_aes_sbox_lane_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         st_valid;
  logic         st_ready;
  logic [127:0] st_in;
  logic         st_out_valid;
  logic         st_out_ready;
  logic [127:0] st_out;
  logic         key_req;
  logic [31:0]  key_word;
  logic         key_done;
  logic [31:0]  key_sub;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit rand_en = 0;
  bit kdrv    = 0;

  logic [127:0] exp_q[$];
  logic [31:0]  key_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_sbox_lane_arbiter #(.KEY_PRIO(1'b1), .NWORDS(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in),
    .st_out_valid(st_out_valid), .st_out_ready(st_out_ready), .st_out(st_out),
    .key_req(key_req), .key_word(key_word), .key_done(key_done), .key_sub(key_sub),
    .sbox_in(sbox_in), .sbox_out(sbox_out)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  function automatic logic [7:0] sbyte(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbyte(w[31:24]), sbyte(w[23:16]), sbyte(w[15:8]), sbyte(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_block(input logic [127:0] d);
    return {sub_word(d[127:96]), sub_word(d[95:64]), sub_word(d[63:32]), sub_word(d[31:0])};
  endfunction

  // external combinational S-box lane
  assign sbox_out = sub_word(sbox_in);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // monitor: pops expectations when outputs are presented
  initial begin : monitor
    bit prev_valid = 0;
    bit prev_kd    = 0;
    bit lat_pend   = 0;
    int acc_m      = 0;
    int lat;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 0; prev_kd = 0; lat_pend = 0;
      end else begin
        if (st_out_valid && !prev_valid && lat_pend) begin
          lat = cyc - acc_m;
          n_cmp++;
          if (lat < 4 || lat > 8) begin
            n_fail++;
            $display("FAIL latency_bound: got %0d expected 4..8", lat);
          end
          lat_pend = 0;
        end
        if (st_out_valid && st_out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL block_unexpected: got %h expected no output", st_out);
          end else check("block", st_out, exp_q.pop_front());
        end
        if (prev_kd) check("key_recovery", {127'd0, key_done}, 128'd0);
        if (key_done) begin
          if (key_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL key_unexpected: got %h expected no pulse", key_sub);
          end else check("key_sub", {96'd0, key_sub}, {96'd0, key_q.pop_front()});
        end
        if (st_valid && st_ready) begin
          acc_m = cyc + 1;
          lat_pend = 1;
        end
        prev_valid = st_out_valid;
        prev_kd    = key_done;
      end
    end
  end

  // random key requester: drops or changes its word during the key_done cycle
  initial begin : key_driver
    forever begin
      @(posedge clk); #1;
      if (kdrv) begin
        if (key_done) begin
          if (rand_en && $urandom_range(0, 1) == 1) begin
            key_word = $urandom;
            key_q.push_back(sub_word(key_word));
          end else key_req = 1'b0;
        end else if (!key_req && rand_en && $urandom_range(0, 2) == 0) begin
          key_word = $urandom;
          key_req  = 1'b1;
          key_q.push_back(sub_word(key_word));
        end
      end
    end
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk); #1;
      if (rand_en) st_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // returns just after the accept edge; acc = cycle number of that edge
  task automatic send_block(input logic [127:0] d, input logic [127:0] e, output int acc);
    bit done = 0;
    acc = 0;
    st_in = d;
    st_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (st_ready) begin
        acc = cyc + 1;
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    st_valid = 1'b0;
    st_in = rnd128();
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end
  endtask

  // returns at the negedge where st_out_valid is first seen
  task automatic wait_valid(output int at);
    bit seen = 0;
    at = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (st_out_valid) begin
        at = cyc;
        seen = 1;
      end
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL valid_timeout: got no valid expected valid");
    end
  endtask

  localparam logic [127:0] T1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] T1_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] T4_IN  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] T4_OUT = 128'h49ded28945db96f17f39871a7702533b;

  initial begin : stim
    int acc, acc2, at;
    logic [127:0] d, held;
    logic [31:0] w2;
    bit pulsed;

    rst = 1'b1; st_valid = 1'b0; st_in = '0; st_out_ready = 1'b1;
    key_req = 1'b0; key_word = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {st_out_valid, key_done, st_ready, key_sub, st_out[31:0]},
          {1'b0, 1'b0, 1'b1, 32'd0, 32'd0});
    check("reset_st_out", st_out, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // key SubWord while idle, request held through the recovery cycle
    key_word = 32'hcf4f3c09; key_req = 1'b1;
    key_q.push_back(32'h8a84eb01);
    @(posedge clk); #1;
    check("t2_key_done_pulse", {127'd0, key_done}, 128'd1);
    check("t2_key_sub", {96'd0, key_sub}, {96'd0, 32'h8a84eb01});
    @(posedge clk); #1;
    check("t2_no_regrant", {127'd0, key_done}, 128'd0);
    key_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // plain block, no key traffic
    send_block(T1_IN, T1_OUT, acc);
    wait_valid(at);
    check("t1_latency", 128'(at - acc), 128'd4);
    @(posedge clk); #1;

    // two key requests won during RUN
    send_block(T1_IN, T1_OUT, acc);
    key_word = 32'hcf4f3c09; key_req = 1'b1;
    key_q.push_back(32'h8a84eb01);
    @(posedge clk); #1;
    check("t3_pulse1", {127'd0, key_done}, 128'd1);
    w2 = $urandom;
    key_word = w2;
    key_q.push_back(sub_word(w2));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t3_pulse2", {127'd0, key_done}, 128'd1);
    key_req = 1'b0;
    wait_valid(at);
    check("t3_latency", 128'(at - acc), 128'd6);
    @(posedge clk); #1;

    // back-to-back: second block accepted in the DONE cycle
    send_block(T1_IN, T1_OUT, acc);
    send_block(T4_IN, T4_OUT, acc2);
    check("t4_b2b_accept", 128'(acc2 - acc), 128'd5);
    wait_valid(at);
    check("t4_latency", 128'(at - acc2), 128'd4);
    @(posedge clk); #1;

    // consumer stall in DONE, key still served
    st_out_ready = 1'b0;
    d = rnd128();
    send_block(d, sub_block(d), acc);
    wait_valid(at);
    held = st_out;
    @(posedge clk); #1;
    key_word = $urandom; key_req = 1'b1;
    key_q.push_back(sub_word(key_word));
    pulsed = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_hold", st_out, held);
      check("t5_ready_low", {st_ready, st_out_valid}, {1'b0, 1'b1});
      @(posedge clk); #1;
      if (key_done) begin
        pulsed = 1;
        key_req = 1'b0;
      end
    end
    check("t5_key_served", {127'd0, pulsed}, 128'd1);
    st_out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;

    // reset mid-block
    d = rnd128();
    send_block(d, sub_block(d), acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t6_reset_now", {st_out_valid, key_done, key_sub}, 34'd0);
    check("t6_reset_st_out", st_out, 128'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    d = rnd128();
    send_block(d, sub_block(d), acc);
    wait_valid(at);
    check("t6_latency", 128'(at - acc), 128'd4);
    @(posedge clk); #1;

    // randomized traffic
    rand_en = 1; kdrv = 1;
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
      d = rnd128();
      send_block(d, sub_block(d), acc);
    end
    rand_en = 0;
    @(posedge clk); #2;
    st_out_ready = 1'b1;
    for (int i = 0; i < 50 && key_req; i++) begin
      @(posedge clk); #2;
    end
    kdrv = 0;
    repeat (20) @(posedge clk);
    #1;
    check("drain_blocks", 128'(exp_q.size()), 128'd0);
    check("drain_keys", 128'(key_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
